// File: rtl/cnn_pkg.sv
// Shared constants and types for the binarized classifier.
// Optional macro CNN_BIAS_EN adds signed per-class biases to the argmax score.
package cnn_pkg;
  localparam int N_PIX   = 784;
  localparam int N_CLASS = 10;
  localparam int ACC_W   = 10;
  localparam int PIX_W   = 10;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {IDLE, LOAD, TAIL, ARGMAX, DONE} state_t;
  typedef logic [ACC_W-1:0] acc_t;

`ifdef CNN_BIAS_EN
  localparam int BIAS_W = 11;
  typedef logic signed [BIAS_W-1:0] bias_t;
  typedef logic signed [ACC_W+1:0]  score_t;

  // acc is 0..784 and bias is -1024..1023, so 12 signed bits cannot overflow
  function automatic score_t to_score(acc_t acc, bias_t bias);
    return score_t'({2'b00, acc}) + score_t'({bias[BIAS_W-1], bias});
  endfunction
`else
  typedef acc_t score_t;
`endif
endpackage

// File: rtl/cnn_if.sv
// Pixel stream, result and weight/bias load bundle of the classifier.
// Bias load signals exist only when CNN_BIAS_EN is defined.
interface cnn_if;
  import cnn_pkg::*;

  logic                      start;
  logic signed [31:0]        din;
  logic                      din_ready;
  logic [N_CLASS-1:0]        classes;
  logic                      done;
  logic                      wt_we;
  logic [PIX_W-1:0]          wt_addr;
  logic [N_CLASS-1:0]        wt_data;
`ifdef CNN_BIAS_EN
  logic                      bias_we;
  logic [IDX_W-1:0]          bias_idx;
  bias_t                     bias_data;

  modport slave  (input  start, din, wt_we, wt_addr, wt_data, bias_we, bias_idx, bias_data,
                  output din_ready, classes, done);
  modport master (output start, din, wt_we, wt_addr, wt_data, bias_we, bias_idx, bias_data,
                  input  din_ready, classes, done);
`else
  modport slave  (input  start, din, wt_we, wt_addr, wt_data,
                  output din_ready, classes, done);
  modport master (output start, din, wt_we, wt_addr, wt_data,
                  input  din_ready, classes, done);
`endif
endinterface

// File: rtl/cnn_argmax.sv
// Sequential argmax, one class per cycle; strict greater-than keeps the lowest index on ties.
// With CNN_BIAS_EN the compared score is the signed sum acc + bias.
module cnn_argmax
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  acc_t               i_acc [N_CLASS],
`ifdef CNN_BIAS_EN
  input  bias_t              i_bias [N_CLASS],
`endif
  output logic               o_last,
  output logic               o_done,
  output logic [N_CLASS-1:0] o_onehot
);
  localparam logic [N_CLASS-1:0] ONE_HOT0 = N_CLASS'(1);

  logic               r_busy;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_best_idx;
  score_t             r_best_val;
  logic               r_done;
  logic [N_CLASS-1:0] r_onehot;
  score_t             w_cur;
  logic               w_take;
  logic [IDX_W-1:0]   w_new_idx;

`ifdef CNN_BIAS_EN
  assign w_cur = to_score(i_acc[r_idx], i_bias[r_idx]);
`else
  assign w_cur = i_acc[r_idx];
`endif

  // class 0 always seeds the running best
  assign w_take    = (r_idx == '0) || (w_cur > r_best_val);
  assign w_new_idx = w_take ? r_idx : r_best_idx;
  assign o_last    = r_busy && (r_idx == IDX_W'(N_CLASS - 1));
  assign o_done    = r_done;
  assign o_onehot  = r_onehot;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy     <= 1'b0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_done     <= 1'b0;
      r_onehot   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if (r_busy) begin
        r_idx      <= r_idx + IDX_W'(1);
        r_best_idx <= w_new_idx;
        if (w_take) begin
          r_best_val <= w_cur;
        end
        if (o_last) begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_onehot <= ONE_HOT0 << w_new_idx;
        end
      end
    end
  end
endmodule

// File: rtl/cnn.sv
// Binarized single-layer classifier: XNOR-counts 784 streamed pixels against a per-class
// weight memory, then runs a sequential argmax. CNN_BIAS_EN enables per-class biases.
module cnn
  import cnn_pkg::*;
#(
  parameter int signed BIN_THRESH = 1
) (
  input  logic clk,
  input  logic rstn,
  cnn_if.slave io_bus
);
  state_t             r_state;
  state_t             w_state_next;
  logic [PIX_W-1:0]   r_pix_cnt;
  logic               r_valid_d;
  logic [N_CLASS-1:0] r_wt_mem [N_PIX];
  logic [N_CLASS-1:0] r_wt_rd;
  acc_t               r_acc [N_CLASS];
  logic               w_start_img;
  logic               w_pix_last;
  logic               w_bit;
  logic               w_din_ready;
  logic               w_am_start;
  logic               w_am_last;
  logic               w_am_done;
  logic [N_CLASS-1:0] w_am_onehot;
  logic [N_CLASS-1:0] w_match;

  assign w_start_img = (r_state == IDLE) && io_bus.start;
  assign w_pix_last  = (r_pix_cnt == PIX_W'(N_PIX - 1));
  assign w_bit       = (io_bus.din >= BIN_THRESH);

  always_comb begin
    w_state_next = r_state;
    w_din_ready  = 1'b0;
    w_am_start   = 1'b0;
    case (r_state)
      IDLE:    if (io_bus.start) w_state_next = LOAD;
      LOAD: begin
        w_din_ready = 1'b1;
        if (w_pix_last) w_state_next = TAIL;
      end
      TAIL: begin
        w_am_start   = 1'b1;
        w_state_next = ARGMAX;
      end
      ARGMAX:  if (w_am_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Weight word for pixel p is read while p is requested, so it lines up with din a cycle later
  always_ff @(posedge clk) begin
    if (io_bus.wt_we) begin
      r_wt_mem[io_bus.wt_addr] <= io_bus.wt_data;
    end
    r_wt_rd <= r_wt_mem[r_pix_cnt];
  end

  generate
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_match
      assign w_match[gi] = ~(w_bit ^ r_wt_rd[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_pix_cnt <= '0;
      r_valid_d <= 1'b0;
      for (int c = 0; c < N_CLASS; c++) r_acc[c] <= '0;
    end else begin
      r_state   <= w_state_next;
      r_valid_d <= w_din_ready;
      if (w_start_img) begin
        r_pix_cnt <= '0;
        for (int c = 0; c < N_CLASS; c++) r_acc[c] <= '0;
      end else begin
        if (w_din_ready && !w_pix_last) begin
          r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
        if (r_valid_d) begin
          for (int c = 0; c < N_CLASS; c++) r_acc[c] <= r_acc[c] + ACC_W'(w_match[c]);
        end
      end
    end
  end

`ifdef CNN_BIAS_EN
  bias_t r_bias [N_CLASS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < N_CLASS; c++) r_bias[c] <= '0;
    end else if (io_bus.bias_we) begin
      r_bias[io_bus.bias_idx] <= io_bus.bias_data;
    end
  end
`endif

  cnn_argmax u_argmax (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (w_am_start),
    .i_acc    (r_acc),
`ifdef CNN_BIAS_EN
    .i_bias   (r_bias),
`endif
    .o_last   (w_am_last),
    .o_done   (w_am_done),
    .o_onehot (w_am_onehot)
  );

  assign io_bus.din_ready = w_din_ready;
  assign io_bus.done      = w_am_done;
  assign io_bus.classes   = w_am_onehot;
endmodule

// File: tb/tb_cnn.sv
// Self-checking bench for cnn: a reference model pushes the expected one-hot class per image
// into a scoreboard queue that is popped and compared when done is seen.
module tb_cnn;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   bias_m [N_CLASS];
  logic [N_CLASS-1:0] exp_q [$];

  cnn_if bus ();

  cnn #(.BIN_THRESH(1)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // 0: all ones, 1: all zeros, 2: ones for p<400, 3: -1/0/1 pattern around the threshold
  function automatic int pix_val(input int k, input int p);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return (p < 400) ? 1 : 0;
      default: return (p % 3) - 1;
    endcase
  endfunction

  // 0: class 0 only, 1: class 7 for p<400, 2: all zero, 3: pseudo-random pattern
  function automatic logic [N_CLASS-1:0] wt_val(input int k, input int p);
    logic [N_CLASS-1:0] v;
    case (k)
      0:       v = 10'b00_0000_0001;
      1:       v = (p < 400) ? 10'b00_1000_0000 : 10'b0;
      2:       v = '0;
      default: v = 10'((p * 37) ^ (p >> 2));
    endcase
    return v;
  endfunction

  function automatic logic [N_CLASS-1:0] model(input int wk, input int ik);
    int acc [N_CLASS];
    int best, bestv, s;
    bit b;
    logic [N_CLASS-1:0] w, one;
    for (int c = 0; c < N_CLASS; c++) acc[c] = 0;
    for (int p = 0; p < N_PIX; p++) begin
      b = (pix_val(ik, p) >= 1);
      w = wt_val(wk, p);
      for (int c = 0; c < N_CLASS; c++) if (b == w[c]) acc[c]++;
    end
    best  = 0;
    bestv = acc[0] + bias_m[0];
    for (int c = 1; c < N_CLASS; c++) begin
      s = acc[c] + bias_m[c];
      if (s > bestv) begin
        best  = c;
        bestv = s;
      end
    end
    one = N_CLASS'(1);
    return one << best;
  endfunction

  task automatic load_weights(input int wk);
    for (int p = 0; p < N_PIX; p++) begin
      @(negedge clk);
      bus.wt_we   = 1'b1;
      bus.wt_addr = PIX_W'(p);
      bus.wt_data = wt_val(wk, p);
    end
    @(negedge clk);
    bus.wt_we = 1'b0;
  endtask

  // Drives one image; cycle numbers are negedges counted from entry. Returns on done or timeout.
  task automatic run_image(input int ik, input bit hold, output int n_ready, output int t0,
                           output int t_last, output int tdone, output bit got_done,
                           output logic [N_CLASS-1:0] cls);
    bit prev_ready = 1'b0;
    int req = 0;
    n_ready = 0; t0 = -1; t_last = -1; tdone = -1; got_done = 1'b0; cls = '0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
      @(negedge clk);
      if (!hold && cyc == 3) bus.start = 1'b0;
      if (prev_ready) begin
        bus.din = pix_val(ik, req);
        req++;
      end else begin
        bus.din = $urandom();
      end
      if (bus.din_ready) begin
        n_ready++;
        if (t0 < 0) t0 = cyc;
        t_last = cyc;
      end
      prev_ready = bus.din_ready;
      if (bus.done) begin
        got_done = 1'b1;
        tdone    = cyc;
        cls      = bus.classes;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.din = '0; bus.wt_we = 1'b0; bus.wt_addr = '0; bus.wt_data = '0;
`ifdef CNN_BIAS_EN
    bus.bias_we = 1'b0; bus.bias_idx = '0; bus.bias_data = '0;
`endif
    for (int c = 0; c < N_CLASS; c++) bias_m[c] = 0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.din_ready !== 1'b0) begin n_err++; $display("FAIL reset din_ready: got %b want 0", bus.din_ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++; if (bus.classes !== '0) begin n_err++; $display("FAIL reset classes: got %b want 0", bus.classes); end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.din_ready !== 1'b0) begin n_err++; $display("FAIL idle din_ready: got %b want 0", bus.din_ready); end
    $display("reset: din_ready=%b done=%b classes=%b", bus.din_ready, bus.done, bus.classes);
  endtask

  task automatic test_single(input string name, input int wk, input int ik);
    int n_ready, t0, t_last, tdone;
    bit got_done;
    logic [N_CLASS-1:0] cls, exp;
    load_weights(wk);
    exp_q.push_back(model(wk, ik));
    run_image(ik, 1'b0, n_ready, t0, t_last, tdone, got_done, cls);
    $display("%s: classes=%b din_ready_cycles=%0d done_at=t0+%0d", name, cls, n_ready, tdone - t0);
    n_cmp++; if (!got_done) begin n_err++; $display("FAIL %s timeout: got no done want done", name); end
    n_cmp++; if (n_ready != N_PIX) begin n_err++; $display("FAIL %s din_ready_count: got %0d want %0d", name, n_ready, N_PIX); end
    n_cmp++; if (t_last - t0 != N_PIX - 1) begin n_err++; $display("FAIL %s din_ready_span: got %0d want %0d", name, t_last - t0, N_PIX - 1); end
    n_cmp++; if (tdone - t0 != 795) begin n_err++; $display("FAIL %s done_latency: got %0d want 795", name, tdone - t0); end
    exp = exp_q.pop_front();
    n_cmp++; if (cls !== exp) begin n_err++; $display("FAIL %s classes: got %b want %b", name, cls, exp); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse: got %b want 0", name, bus.done); end
    n_cmp++; if (bus.classes !== exp) begin n_err++; $display("FAIL %s classes_hold: got %b want %b", name, bus.classes, exp); end
  endtask

  task automatic test_back_to_back();
    int n_ready, t0, t_last, tdone;
    bit got_done;
    logic [N_CLASS-1:0] cls, exp;
    load_weights(0);
    exp_q.push_back(model(0, 0));
    run_image(0, 1'b1, n_ready, t0, t_last, tdone, got_done, cls);
    exp = exp_q.pop_front();
    $display("b2b first: classes=%b done_at=t0+%0d", cls, tdone - t0);
    n_cmp++; if (!got_done || cls !== exp) begin n_err++; $display("FAIL b2b first_classes: got %b want %b", cls, exp); end
    exp_q.push_back(model(0, 1));
    run_image(1, 1'b1, n_ready, t0, t_last, tdone, got_done, cls);
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    $display("b2b second: classes=%b t0=done+%0d done_at=t0+%0d", cls, t0, tdone - t0);
    n_cmp++; if (t0 != 2) begin n_err++; $display("FAIL b2b restart_gap: got %0d want 2", t0); end
    n_cmp++; if (n_ready != N_PIX) begin n_err++; $display("FAIL b2b din_ready_count: got %0d want %0d", n_ready, N_PIX); end
    n_cmp++; if (tdone - t0 != 795) begin n_err++; $display("FAIL b2b done_latency: got %0d want 795", tdone - t0); end
    n_cmp++; if (!got_done || cls !== exp) begin n_err++; $display("FAIL b2b second_classes: got %b want %b", cls, exp); end
  endtask

  task automatic test_abort();
    int n_ready = 0;
    int n_done = 0;
    bit aborted = 1'b0;
    int t0, t_last, tdone;
    bit got_done;
    logic [N_CLASS-1:0] cls, exp;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 400 && !aborted; cyc++) begin
      @(negedge clk);
      bus.din = 1;
      if (bus.din_ready) n_ready++;
      if (bus.done) n_done++;
      if (n_ready == 300) begin
        rstn      = 1'b0;
        bus.start = 1'b0;
        aborted   = 1'b1;
      end
    end
    #1;
    $display("abort: at pixel %0d din_ready=%b done=%b classes=%b", n_ready, bus.din_ready, bus.done, bus.classes);
    n_cmp++; if (!aborted) begin n_err++; $display("FAIL abort reached_pixel: got %0d want 300", n_ready); end
    n_cmp++; if (bus.din_ready !== 1'b0) begin n_err++; $display("FAIL abort din_ready: got %b want 0", bus.din_ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort done: got %b want 0", bus.done); end
    n_cmp++; if (bus.classes !== '0) begin n_err++; $display("FAIL abort classes: got %b want 0", bus.classes); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || n_done != 0) begin n_err++; $display("FAIL abort no_done: got %0d want 0", n_done + int'(bus.done)); end
    rstn = 1'b1;
    @(negedge clk);
    exp_q.push_back(model(0, 0));
    run_image(0, 1'b0, n_ready, t0, t_last, tdone, got_done, cls);
    exp = exp_q.pop_front();
    $display("after abort: classes=%b din_ready_cycles=%0d done_at=t0+%0d", cls, n_ready, tdone - t0);
    n_cmp++; if (n_ready != N_PIX) begin n_err++; $display("FAIL abort reload_count: got %0d want %0d", n_ready, N_PIX); end
    n_cmp++; if (tdone - t0 != 795) begin n_err++; $display("FAIL abort reload_latency: got %0d want 795", tdone - t0); end
    n_cmp++; if (!got_done || cls !== exp) begin n_err++; $display("FAIL abort reload_classes: got %b want %b", cls, exp); end
    @(negedge clk);
  endtask

`ifdef CNN_BIAS_EN
  task automatic test_bias();
    @(negedge clk);
    bus.bias_we   = 1'b1;
    bus.bias_idx  = 4'd4;
    bus.bias_data = 11'sd5;
    @(negedge clk);
    bus.bias_we = 1'b0;
    bias_m[4] = 5;
    test_single("bias", 2, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single("class0_ones", 0, 0);
    test_single("tie_zeros", 0, 1);
    test_single("class7_half", 1, 2);
    test_single("mixed_pattern", 3, 3);
    test_back_to_back();
    test_abort();
`ifdef CNN_BIAS_EN
    test_bias();
`endif
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
